priority_encoder_16to4: RTL and testbench

//  Inverse of the team's 4-to-16 decoder: accepts a 16-bit request vector, latches it, and

---
 rtl/prio_enc_pkg.sv | 12 +
 rtl/priority_encoder_16to4_if.sv | 26 ++
 rtl/priority_encoder_16to4_pick.sv | 33 +++
 rtl/priority_encoder_16to4.sv | 83 ++++++++
 tb/tb_priority_encoder_16to4.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/prio_enc_pkg.sv
// Shared types and sizing for the 16-to-4 priority encoder.
package prio_enc_pkg;

    localparam int N_DEF = 16;
    localparam int W_DEF = $clog2(N_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/priority_encoder_16to4_if.sv
// Request/response bundle between the request sources, the encoder and the code consumer.
interface priority_encoder_16to4_if #(
    parameter int N = prio_enc_pkg::N_DEF
);
    localparam int W = $clog2(N);

    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_code;
    logic         out_last;
    logic         busy;

    modport master (
        output req_valid, req, out_ready,
        input  req_ready, out_valid, out_code, out_last, busy
    );

    modport slave (
        input  req_valid, req, out_ready,
        output req_ready, out_valid, out_code, out_last, busy
    );

endinterface

// File: rtl/priority_encoder_16to4_pick.sv
// Find-first-set over N bits starting at a W-bit base, wrapping N-1 -> 0.
module prio_pick #(
    parameter int N = prio_enc_pkg::N_DEF,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] base,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   ff;
    logic           found;

    always_comb begin
        dbl   = {vec, vec};
        rot   = dbl[base +: N];
        ff    = '0;
        found = 1'b0;
        // Descending scan so the lowest rotated position is the one left standing.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                ff    = W'(i);
                found = 1'b1;
            end
        end
        idx    = ff + base;
        onehot = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/priority_encoder_16to4.sv
// Latches a request vector and emits the index of each set bit, one per handshake.
// Define PRIO_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index-first.
//
//  state | meaning
//  IDLE  | ready for a new vector, no output
//  EMIT  | pending non-zero, presenting selected code
module priority_encoder_16to4
    import prio_enc_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    priority_encoder_16to4_if.slave    bus
);

    localparam int W = $clog2(N);

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] pending;
    logic [W-1:0] pick_base;
    logic [W-1:0] pick_idx;
    logic [N-1:0] pick_onehot;
    logic         take;
    logic         last;

`ifdef PRIO_ROUND_ROBIN_EN
    logic [W-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= pick_idx + W'(1);
        end
    end

    assign pick_base = ptr;
`else
    assign pick_base = '0;
`endif

    prio_pick #(.N(N)) u_pick (
        .vec    (pending),
        .base   (pick_base),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign take = (state == EMIT) && bus.out_ready;
    assign last = (pending != '0) && ((pending & (pending - N'(1))) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.req_valid) begin
                pending <= bus.req;
            end else if (take) begin
                pending <= pending & ~pick_onehot;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.req_valid && bus.req != '0) state_nxt = EMIT;
            EMIT: if (take && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.out_valid = (state == EMIT);
    assign bus.out_code  = (state == EMIT) ? pick_idx : '0;
    assign bus.out_last  = last;
    assign bus.busy      = |pending;

endmodule

// File: tb/tb_priority_encoder_16to4.sv
// Self-checking bench: queue-based model of emitted codes plus directed literal scenarios.
module tb_priority_encoder_16to4;

    localparam int N = prio_enc_pkg::N_DEF;

    logic clk;
    logic rst_n;

    priority_encoder_16to4_if #(.N(N)) bus ();

    priority_encoder_16to4 #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int q[$];
    int m_ptr = 0;
    int log_code[$];
    int log_last[$];
    bit rand_ready = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Expected emission order for a vector: ascending from the start index, wrapping.
    function automatic void build(logic [N-1:0] v);
        int start;
        start = 0;
`ifdef PRIO_ROUND_ROBIN_EN
        start = m_ptr;
`endif
        for (int j = 0; j < N; j++) begin
            int k;
            k = (start + j) % N;
            if (v[k]) q.push_back(k);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_ptr = 0;
            check("rst_req_ready", bus.req_ready, 1);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_out_code", bus.out_code, 0);
            check("rst_out_last", bus.out_last, 0);
            check("rst_busy", bus.busy, 0);
        end else begin
            check("req_ready", bus.req_ready, q.size() == 0);
            check("out_valid", bus.out_valid, q.size() != 0);
            check("busy", bus.busy, q.size() != 0);
            check("out_last", bus.out_last, q.size() == 1);
            check("out_code", bus.out_code, (q.size() != 0) ? q[0] : 0);
            if (q.size() != 0) begin
                if (bus.out_ready) begin
                    m_ptr = (q[0] + 1) % N;
                    void'(q.pop_front());
                end
            end else if (bus.req_valid) begin
                build(bus.req);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            log_code.push_back(bus.out_code);
            log_last.push_back(bus.out_last);
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(logic [N-1:0] v);
        bit ok;
        int n;
        n = 0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req       = v;
        do begin
            @(negedge clk);
            ok = bus.req_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("send_timeout", 0, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!bus.out_valid && bus.req_ready) done = 1;
        end
        if (!done) check("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        log_code.delete();
        log_last.delete();
    endtask

    task automatic check_log(string name, int n, int e0, int e1, int e2, int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        check({name, "_count"}, log_code.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < log_code.size()) begin
                check({name, "_code"}, log_code[i], e[i]);
                check({name, "_last"}, log_last[i], i == n - 1);
            end
        end
        log_code.delete();
        log_last.delete();
    endtask

    initial begin
        logic [N-1:0] v;

        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req       = '1;
        bus.out_ready = 1'b1;

        // Reset held with a request offered: nothing may be accepted.
        repeat (3) @(negedge clk);
        check("t1_req_ready", bus.req_ready, 1);
        check("t1_out_valid", bus.out_valid, 0);
        check("t1_out_code", bus.out_code, 0);
        check("t1_busy", bus.busy, 0);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        log_code.delete();
        log_last.delete();

        send(16'h8421);
        wait_idle();
        check_log("t2", 4, 0, 5, 10, 15);

        do_reset();
        send(16'h0000);
        @(negedge clk);
        check("t3_out_valid", bus.out_valid, 0);
        check("t3_req_ready", bus.req_ready, 1);

        bus.out_ready = 1'b0;
        send(16'h0006);
        repeat (3) begin
            @(negedge clk);
            check("t4_hold_valid", bus.out_valid, 1);
            check("t4_hold_code", bus.out_code, 1);
            check("t4_hold_last", bus.out_last, 0);
        end
        bus.out_ready = 1'b1;
        wait_idle();
        check_log("t4", 2, 1, 2, 0, 0);

        do_reset();
        send(16'h0003);
        wait_idle();
        check_log("t5a", 2, 0, 1, 0, 0);
        send(16'h8001);
        wait_idle();
`ifdef PRIO_ROUND_ROBIN_EN
        check_log("t5b", 2, 15, 0, 0, 0);
`else
        check_log("t5b", 2, 0, 15, 0, 0);
`endif

        do_reset();
        send(16'hFFFF);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_req_ready", bus.req_ready, 1);
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_out_code", bus.out_code, 0);
        check("t6_out_last", bus.out_last, 0);
        check("t6_busy", bus.busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        log_code.delete();
        log_last.delete();
        send(16'h0010);
        wait_idle();
        check_log("t6", 1, 4, 0, 0, 0);

        rand_ready = 1;
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 7))
                0:       v = '0;
                1:       v = N'(1) << $urandom_range(0, N - 1);
                2:       v = '1;
                default: v = N'($urandom);
            endcase
            send(v);
        end
        wait_idle();
        rand_ready = 0;
        #2;
        bus.out_ready = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
